// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-port bus between the CPU memory stage,
// the load/store unit and port 1 of the byte-addressed memory.
interface load_store_unit_if;
  // CPU request
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // CPU response
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  // Memory data port
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_read_data;

  // Load/store unit side
  modport slave (
    input  req_valid,
    output req_ready,
    input  req_write,
    input  req_funct3,
    input  req_addr,
    input  req_wdata,
    output rsp_valid,
    input  rsp_ready,
    output rsp_rdata,
    output rsp_fault,
    output mem_write_en,
    output mem_address,
    output mem_write_data,
    output mem_byte_enable,
    input  mem_read_data
  );

  // CPU and memory side
  modport master (
    output req_valid,
    input  req_ready,
    output req_write,
    output req_funct3,
    output req_addr,
    output req_wdata,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_rdata,
    input  rsp_fault,
    input  mem_write_en,
    input  mem_address,
    input  mem_write_data,
    input  mem_byte_enable,
    output mem_read_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Non-pipelined load/store unit: turns one CPU load or store into a word-aligned,
// byte-enabled access on the memory data port and returns extended load data.
// Misaligned accesses and illegal width codes are answered with a fault and
// never reach memory.
module load_store_unit #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  byte_enable_q, byte_enable_d;
  logic [31:0] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  // Decoded view of the request currently on the bus
  logic        req_fault;
  logic [3:0]  req_byte_enable;
  logic [31:0] req_lane_data;
  logic [4:0]  req_shift;

  // Load data path
  logic [31:0] shifted_rdata;
  logic [31:0] load_value;

  // Classify the incoming request and map it onto byte lanes.
  always_comb begin
    req_fault = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b100: req_fault = 1'b0;
      3'b001, 3'b101: req_fault = bus.req_addr[0];
      3'b010:         req_fault = |bus.req_addr[1:0];
      default:        req_fault = 1'b1;
    endcase
    // Unsigned widths only exist for loads
    if (bus.req_write && bus.req_funct3[2]) begin
      req_fault = 1'b1;
    end

    req_shift = {bus.req_addr[1:0], 3'b000};
    case (bus.req_funct3[1:0])
      2'b00: begin
        req_byte_enable = 4'b0001 << bus.req_addr[1:0];
        req_lane_data   = bus.req_wdata << req_shift;
      end
      2'b01: begin
        req_byte_enable = 4'b0011 << bus.req_addr[1:0];
        req_lane_data   = bus.req_wdata << req_shift;
      end
      default: begin
        req_byte_enable = 4'b1111;
        req_lane_data   = bus.req_wdata;
      end
    endcase
  end

  // Align the returned word to the addressed byte and extend per width code.
  always_comb begin
    shifted_rdata = bus.mem_read_data >> {offset_q, 3'b000};
    case (funct3_q)
      3'b000:  load_value = {{24{shifted_rdata[7]}}, shifted_rdata[7:0]};
      3'b001:  load_value = {{16{shifted_rdata[15]}}, shifted_rdata[15:0]};
      3'b100:  load_value = {24'h000000, shifted_rdata[7:0]};
      3'b101:  load_value = {16'h0000, shifted_rdata[15:0]};
      default: load_value = shifted_rdata;
    endcase
  end

  // Next-state logic and handshake/memory strobes.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    funct3_d      = funct3_q;
    offset_d      = offset_q;
    count_d       = count_q;
    byte_enable_d = byte_enable_q;
    address_d     = address_q;
    write_data_d  = write_data_q;
    rdata_d       = rdata_q;
    fault_d       = fault_q;

    bus.req_ready       = 1'b0;
    bus.rsp_valid       = 1'b0;
    bus.mem_write_en    = 1'b0;
    bus.mem_byte_enable = 4'b0000;

    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          funct3_d = bus.req_funct3;
          offset_d = bus.req_addr[1:0];
          rdata_d  = 32'h0;
          fault_d  = req_fault;
          if (req_fault) begin
            state_d = StResp;
          end else begin
            // Bus address/data only move on a real access so they hold otherwise
            state_d       = StAccess;
            count_d       = 4'(WAIT_CYCLES);
            byte_enable_d = req_byte_enable;
            address_d     = {bus.req_addr[31:2], 2'b00};
            write_data_d  = req_lane_data;
          end
        end
      end
      StAccess: begin
        bus.mem_byte_enable = byte_enable_q;
        if (count_q == 4'd0) begin
          bus.mem_write_en = write_q;
          if (!write_q) begin
            rdata_d = load_value;
          end
          state_d = StResp;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      StResp: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.mem_address    = address_q;
  assign bus.mem_write_data = write_data_q;
  assign bus.rsp_rdata      = rdata_q;
  assign bus.rsp_fault      = fault_q;

  // State and transaction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      write_q       <= 1'b0;
      funct3_q      <= 3'b000;
      offset_q      <= 2'b00;
      count_q       <= 4'd0;
      byte_enable_q <= 4'b0000;
      address_q     <= 32'h0;
      write_data_q  <= 32'h0;
      rdata_q       <= 32'h0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      funct3_q      <= funct3_d;
      offset_q      <= offset_d;
      count_q       <= count_d;
      byte_enable_q <= byte_enable_d;
      address_q     <= address_d;
      write_data_q  <= write_data_d;
      rdata_q       <= rdata_d;
      fault_q       <= fault_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: one instance with no wait states and one with three,
// each attached to a byte-array memory. Directed vectors, hand-written multi-cycle
// sequences and random traffic checked against a byte-level reference memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit_if bus0 ();
  load_store_unit_if bus3 ();

  load_store_unit #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  load_store_unit #(.WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Per-instance drive and observe arrays (index 0 -> bus0, 1 -> bus3)
  logic        req_valid_v [2];
  logic        req_write_v [2];
  logic [2:0]  req_funct3_v [2];
  logic [31:0] req_addr_v [2];
  logic [31:0] req_wdata_v [2];
  logic        rsp_ready_v [2];
  logic        req_ready_w [2];
  logic        rsp_valid_w [2];
  logic        rsp_fault_w [2];
  logic        mem_we_w [2];
  logic [31:0] rsp_rdata_w [2];
  logic [31:0] mem_addr_w [2];
  logic [31:0] mem_wdata_w [2];
  logic [3:0]  mem_be_w [2];

  assign bus0.req_valid  = req_valid_v[0];
  assign bus0.req_write  = req_write_v[0];
  assign bus0.req_funct3 = req_funct3_v[0];
  assign bus0.req_addr   = req_addr_v[0];
  assign bus0.req_wdata  = req_wdata_v[0];
  assign bus0.rsp_ready  = rsp_ready_v[0];
  assign bus3.req_valid  = req_valid_v[1];
  assign bus3.req_write  = req_write_v[1];
  assign bus3.req_funct3 = req_funct3_v[1];
  assign bus3.req_addr   = req_addr_v[1];
  assign bus3.req_wdata  = req_wdata_v[1];
  assign bus3.rsp_ready  = rsp_ready_v[1];

  assign req_ready_w[0] = bus0.req_ready;
  assign rsp_valid_w[0] = bus0.rsp_valid;
  assign rsp_fault_w[0] = bus0.rsp_fault;
  assign rsp_rdata_w[0] = bus0.rsp_rdata;
  assign mem_we_w[0]    = bus0.mem_write_en;
  assign mem_addr_w[0]  = bus0.mem_address;
  assign mem_wdata_w[0] = bus0.mem_write_data;
  assign mem_be_w[0]    = bus0.mem_byte_enable;
  assign req_ready_w[1] = bus3.req_ready;
  assign rsp_valid_w[1] = bus3.rsp_valid;
  assign rsp_fault_w[1] = bus3.rsp_fault;
  assign rsp_rdata_w[1] = bus3.rsp_rdata;
  assign mem_we_w[1]    = bus3.mem_write_en;
  assign mem_addr_w[1]  = bus3.mem_address;
  assign mem_wdata_w[1] = bus3.mem_write_data;
  assign mem_be_w[1]    = bus3.mem_byte_enable;

  // Little-endian byte memories, 1 KiB each, aliased on address bits [9:0]
  logic [7:0] mem [2][1024];
  logic       mem_clear;
  int         cyc = 0;
  int         we_total [2] = '{0, 0};
  int         we_cyc [2] = '{0, 0};

  assign bus0.mem_read_data = {mem[0][{bus0.mem_address[9:2], 2'd3}],
                               mem[0][{bus0.mem_address[9:2], 2'd2}],
                               mem[0][{bus0.mem_address[9:2], 2'd1}],
                               mem[0][{bus0.mem_address[9:2], 2'd0}]};
  assign bus3.mem_read_data = {mem[1][{bus3.mem_address[9:2], 2'd3}],
                               mem[1][{bus3.mem_address[9:2], 2'd2}],
                               mem[1][{bus3.mem_address[9:2], 2'd1}],
                               mem[1][{bus3.mem_address[9:2], 2'd0}]};

  // Memory writes, write-pulse bookkeeping and cycle count.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) begin
        mem[0][i] <= 8'h00;
        mem[1][i] <= 8'h00;
      end
    end else begin
      if (bus0.mem_write_en) begin
        for (int b = 0; b < 4; b++) begin
          if (bus0.mem_byte_enable[b]) begin
            mem[0][{bus0.mem_address[9:2], 2'(b)}] <= bus0.mem_write_data[8*b +: 8];
          end
        end
        we_total[0] <= we_total[0] + 1;
        we_cyc[0]   <= cyc;
      end
      if (bus3.mem_write_en) begin
        for (int b = 0; b < 4; b++) begin
          if (bus3.mem_byte_enable[b]) begin
            mem[1][{bus3.mem_address[9:2], 2'(b)}] <= bus3.mem_write_data[8*b +: 8];
          end
        end
        we_total[1] <= we_total[1] + 1;
        we_cyc[1]   <= cyc;
      end
    end
  end

  // Reference memory shadowing instance 0
  logic [7:0] ref_mem [1024];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Architectural load/store behaviour on a byte array.
  task automatic ref_txn(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output bit fault);
    int sz;
    bit sgn;
    int a;
    logic [31:0] v;
    logic [31:0] mask;
    sgn = 1'b0;
    case (f3)
      3'd0: begin sz = 1; sgn = 1'b1; end
      3'd1: begin sz = 2; sgn = 1'b1; end
      3'd2: sz = 4;
      3'd4: sz = 1;
      3'd5: sz = 2;
      default: sz = 0;
    endcase
    if (sz == 0) fault = 1'b1;
    else fault = (wr && f3 > 3'd2) || ((addr % sz) != 0);
    rdata = 32'h0;
    if (!fault) begin
      a = int'(addr[9:0]);
      if (wr) begin
        for (int i = 0; i < sz; i++) ref_mem[a + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
        if (sz < 4) begin
          mask = (32'd1 << (8 * sz)) - 32'd1;
          if (sgn && v[8*sz-1]) v = v | ~mask;
        end
        rdata = v;
      end
    end
  endtask

  // Expected byte enables and lane data for an accepted request.
  task automatic ref_lanes(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [3:0] be, output logic [31:0] lane);
    int sz;
    int o;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    o  = int'(addr % 4);
    be = 4'(((1 << sz) - 1) << o);
    lane = (sz == 4) ? wdata : (wdata << (8 * o));
  endtask

  // One complete transaction with all handshake, bus and timing checks.
  task automatic do_txn(input int sel, input string name, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        input logic [31:0] exp_rdata, input bit exp_fault,
                        input logic [3:0] exp_be, input logic [31:0] exp_lane);
    int wait_n;
    int c0;
    int we0;
    int lat;
    bit exp_we;
    wait_n = (sel == 1) ? 3 : 0;
    exp_we = wr && !exp_fault;
    @(negedge clk);
    req_valid_v[sel]  = 1'b1;
    req_write_v[sel]  = wr;
    req_funct3_v[sel] = f3;
    req_addr_v[sel]   = addr;
    req_wdata_v[sel]  = wdata;
    rsp_ready_v[sel]  = (hold == 0);
    for (int g = 0; g < 20 && !req_ready_w[sel]; g++) @(negedge clk);
    check({name, "_req_ready"}, 32'(req_ready_w[sel]), 32'd1);
    we0 = we_total[sel];
    c0  = cyc;
    @(negedge clk);
    lat = 1;
    // Request fields change after accept and must be ignored
    req_valid_v[sel]  = 1'b0;
    req_write_v[sel]  = 1'($urandom);
    req_funct3_v[sel] = 3'($urandom);
    req_addr_v[sel]   = $urandom;
    req_wdata_v[sel]  = $urandom;
    check({name, "_be"}, 32'(mem_be_w[sel]), exp_fault ? 32'd0 : 32'(exp_be));
    if (!exp_fault) begin
      check({name, "_addr"}, mem_addr_w[sel], addr & ~32'h3);
      check({name, "_wdata"}, mem_wdata_w[sel], exp_lane);
    end
    while (!rsp_valid_w[sel] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, exp_fault ? 32'd1 : 32'(2 + wait_n));
    check({name, "_rdata"}, rsp_rdata_w[sel], exp_rdata);
    check({name, "_fault"}, 32'(rsp_fault_w[sel]), 32'(exp_fault));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(rsp_valid_w[sel]), 32'd1);
      check({name, "_hold_rdata"}, rsp_rdata_w[sel], exp_rdata);
      check({name, "_hold_fault"}, 32'(rsp_fault_w[sel]), 32'(exp_fault));
      check({name, "_hold_req_ready"}, 32'(req_ready_w[sel]), 32'd0);
    end
    rsp_ready_v[sel] = 1'b1;
    @(negedge clk);
    rsp_ready_v[sel] = 1'b0;
    check({name, "_ready_after_rsp"}, 32'(req_ready_w[sel]), 32'd1);
    check({name, "_valid_after_rsp"}, 32'(rsp_valid_w[sel]), 32'd0);
    check({name, "_we_count"}, we_total[sel] - we0, 32'(exp_we));
    if (exp_we) check({name, "_we_cycle"}, we_cyc[sel] - c0, 32'(1 + wait_n));
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          fault;
    logic [3:0]  be;
    logic [31:0] lane;
  } vec_t;

  localparam int NumVec = 17;
  vec_t tbl [NumVec];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [31:0] er;
    bit          ef;
    logic [3:0]  ebe;
    logic [31:0] elane;
    logic [31:0] word;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          diffs;
    int          we0;

    for (int s = 0; s < 2; s++) begin
      req_valid_v[s] = 1'b0; req_write_v[s] = 1'b0; req_funct3_v[s] = 3'd0;
      req_addr_v[s] = 32'h0; req_wdata_v[s] = 32'h0; rsp_ready_v[s] = 1'b0;
    end
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    //          wr    f3    addr        wdata         rdata         flt   be    lane
    tbl[0]  = '{1'b1, 3'd2, 32'h100, 32'h1122_3344, 32'h0000_0000, 1'b0, 4'hF, 32'h1122_3344};
    tbl[1]  = '{1'b0, 3'd2, 32'h100, 32'h0,         32'h1122_3344, 1'b0, 4'hF, 32'h0};
    tbl[2]  = '{1'b0, 3'd0, 32'h103, 32'h0,         32'h0000_0011, 1'b0, 4'h8, 32'h0};
    tbl[3]  = '{1'b0, 3'd1, 32'h102, 32'h0,         32'h0000_1122, 1'b0, 4'hC, 32'h0};
    tbl[4]  = '{1'b1, 3'd0, 32'h101, 32'h0000_0080, 32'h0000_0000, 1'b0, 4'h2, 32'h0000_8000};
    tbl[5]  = '{1'b0, 3'd0, 32'h101, 32'h0,         32'hFFFF_FF80, 1'b0, 4'h2, 32'h0};
    tbl[6]  = '{1'b0, 3'd4, 32'h101, 32'h0,         32'h0000_0080, 1'b0, 4'h2, 32'h0};
    tbl[7]  = '{1'b0, 3'd2, 32'h100, 32'h0,         32'h1122_8044, 1'b0, 4'hF, 32'h0};
    tbl[8]  = '{1'b1, 3'd1, 32'h102, 32'h0000_BEEF, 32'h0000_0000, 1'b0, 4'hC, 32'hBEEF_0000};
    tbl[9]  = '{1'b0, 3'd5, 32'h102, 32'h0,         32'h0000_BEEF, 1'b0, 4'hC, 32'h0};
    tbl[10] = '{1'b0, 3'd1, 32'h102, 32'h0,         32'hFFFF_BEEF, 1'b0, 4'hC, 32'h0};
    tbl[11] = '{1'b0, 3'd2, 32'h102, 32'h0,         32'h0,         1'b1, 4'h0, 32'h0};
    tbl[12] = '{1'b1, 3'd1, 32'h101, 32'h0000_1234, 32'h0,         1'b1, 4'h0, 32'h0};
    tbl[13] = '{1'b0, 3'd3, 32'h100, 32'h0,         32'h0,         1'b1, 4'h0, 32'h0};
    tbl[14] = '{1'b1, 3'd4, 32'h100, 32'h0000_0055, 32'h0,         1'b1, 4'h0, 32'h0};
    tbl[15] = '{1'b0, 3'd7, 32'h100, 32'h0,         32'h0,         1'b1, 4'h0, 32'h0};
    tbl[16] = '{1'b0, 3'd2, 32'h100, 32'h0,         32'hBEEF_8044, 1'b0, 4'hF, 32'h0};

    // Reset and memory clear
    rst = 1'b1;
    mem_clear = 1'b1;
    repeat (3) @(negedge clk);
    mem_clear = 1'b0;
    check("reset_req_ready", 32'(req_ready_w[0]), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid_w[0]), 32'd0);
    check("reset_rsp_rdata", rsp_rdata_w[0], 32'h0);
    check("reset_rsp_fault", 32'(rsp_fault_w[0]), 32'd0);
    check("reset_write_en", 32'(mem_we_w[0]), 32'd0);
    check("reset_byte_enable", 32'(mem_be_w[0]), 32'd0);
    check("reset_address", mem_addr_w[0], 32'h0);
    check("reset_write_data", mem_wdata_w[0], 32'h0);
    rst = 1'b0;

    // Directed vectors, no wait states
    for (int i = 0; i < NumVec; i++) begin
      ref_txn(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, er, ef);
      do_txn(0, $sformatf("vec%0d", i), tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, i % 3,
             tbl[i].rdata, tbl[i].fault, tbl[i].be, tbl[i].lane);
      if (i == 0) begin
        word = {mem[0][259], mem[0][258], mem[0][257], mem[0][256]};
        check("vec0_mem_bytes", word, 32'h1122_3344);
      end
    end
    word = {mem[0][259], mem[0][258], mem[0][257], mem[0][256]};
    check("vec_final_mem_bytes", word, 32'hBEEF_8044);

    // Three wait states, response back-pressured for five cycles
    do_txn(1, "w3_sw", 1'b1, 3'd2, 32'h40, 32'hCAFE_F00D, 5, 32'h0, 1'b0, 4'hF, 32'hCAFE_F00D);
    do_txn(1, "w3_lw", 1'b0, 3'd2, 32'h40, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 4'hF, 32'h0);
    do_txn(1, "w3_lhfault", 1'b0, 3'd1, 32'h41, 32'h0, 2, 32'h0, 1'b1, 4'h0, 32'h0);

    // Reset in the middle of a store's wait states: the write must never happen
    @(negedge clk);
    req_valid_v[1] = 1'b1; req_write_v[1] = 1'b1; req_funct3_v[1] = 3'd2;
    req_addr_v[1] = 32'h84; req_wdata_v[1] = 32'h1234_5678; rsp_ready_v[1] = 1'b1;
    check("rstseq_req_ready", 32'(req_ready_w[1]), 32'd1);
    we0 = we_total[1];
    @(negedge clk);
    req_valid_v[1] = 1'b0;
    check("rstseq_in_access", 32'(mem_be_w[1]), 32'hF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstseq_req_ready_after", 32'(req_ready_w[1]), 32'd1);
    check("rstseq_rsp_valid", 32'(rsp_valid_w[1]), 32'd0);
    check("rstseq_rsp_rdata", rsp_rdata_w[1], 32'h0);
    check("rstseq_rsp_fault", 32'(rsp_fault_w[1]), 32'd0);
    check("rstseq_write_en", 32'(mem_we_w[1]), 32'd0);
    check("rstseq_byte_enable", 32'(mem_be_w[1]), 32'd0);
    check("rstseq_address", mem_addr_w[1], 32'h0);
    check("rstseq_write_data", mem_wdata_w[1], 32'h0);
    repeat (6) @(negedge clk);
    check("rstseq_no_late_rsp", 32'(rsp_valid_w[1]), 32'd0);
    check("rstseq_no_write", we_total[1] - we0, 32'd0);
    word = {mem[1][135], mem[1][134], mem[1][133], mem[1][132]};
    check("rstseq_mem_untouched", word, 32'h0);
    do_txn(1, "rstseq_lw", 1'b0, 3'd2, 32'h84, 32'h0, 1, 32'h0, 1'b0, 4'hF, 32'h0);

    // Random traffic against the reference memory
    for (int n = 0; n < 150; n++) begin
      wr    = 1'($urandom);
      f3    = 3'($urandom_range(0, 7));
      addr  = ($urandom & 32'hFFFF_FC00) | (32'h1C0 + 32'($urandom_range(0, 63)));
      wdata = $urandom;
      ref_txn(wr, f3, addr, wdata, er, ef);
      ref_lanes(f3, addr, wdata, ebe, elane);
      do_txn(0, "rand", wr, f3, addr, wdata, $urandom_range(0, 2), er, ef, ebe, elane);
    end
    diffs = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem[0][i] !== ref_mem[i]) diffs++;
    end
    check("ref_mem_diffs", diffs, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port: accepts one load or store per transaction from the CPU memory stage, converts it into a word-aligned byte-enabled access on the data port (port 1) of the byte-addressed little-endian `memory` block, and returns sign/zero-extended load data. Misaligned accesses and illegal width codes are rejected before they reach memory. Non-pipelined: one outstanding transaction, valid/ready handshake on both request and response sides.

## Interface
- `WAIT_CYCLES`, default 0: extra cycles the access is held on the memory port before write/capture (0..15).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, value in low bits.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_rdata` out 32: extended load data; 0 for stores and faults.
- `rsp_fault` out 1: misaligned or illegal width; no memory effect.
- `mem_write_en` out 1: to memory `port1_write_en`.
- `mem_address` out 32: to `port1_address`; always word-aligned.
- `mem_write_data` out 32: to `port1_write_data`.
- `mem_byte_enable` out 4: to `port1_byte_enable`.
- `mem_read_data` in 32: from `port1_read_data` (combinational in memory).

## Operation
- States: IDLE, ACCESS, RESP. `req_ready` = (state == IDLE).
- IDLE: on `req_valid`: register request. If fault -> RESP with `rsp_fault`=1; else -> ACCESS, wait counter = `WAIT_CYCLES`.
- Fault: funct3 in {011,110,111}; store with funct3[2]=1; H/HU with addr[0]=1; W with addr[1:0]!=0.
- Lane mapping (o = addr[1:0]): `mem_address` = {addr[31:2],2'b00}; byte enable B: 0001<<o, H: 0011<<o, W: 1111; `mem_write_data` = req_wdata << 8*o (B/H lanes), unshifted for W.
- ACCESS: address/byte enables/write data driven every cycle. Counter decrements; when 0 (last ACCESS cycle): store -> `mem_write_en`=1 that cycle only; load -> capture `mem_read_data >> 8*o`, extend per funct3 (B/H sign, BU/HU zero, W none) into `rsp_rdata`. -> RESP.
- Outside ACCESS: `mem_write_en`=0, `mem_byte_enable`=0; `mem_address`/`mem_write_data` hold last values.
- RESP: `rsp_valid`=1, `rsp_rdata`/`rsp_fault` stable until `rsp_ready`; then -> IDLE (no same-cycle new accept; `req_ready` rises next cycle).
- Request fields are sampled only at accept; later changes ignored.

## Timing
- Accept at edge T (req_valid & req_ready). ACCESS cycles T+1..T+1+WAIT_CYCLES. `rsp_valid` high from cycle T+2+WAIT_CYCLES. Fault: `rsp_valid` at T+1.
- Store write lands in memory at end of last ACCESS cycle; a load accepted afterward sees it.
- Throughput: at best one transaction per 3+WAIT_CYCLES cycles.
- Reset (any state, including mid-ACCESS): next state IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0, `mem_write_en`=0, `mem_byte_enable`=0, `mem_address`=0, `mem_write_data`=0, counter 0; in-flight transaction dropped, no write issued after reset edge. `req_ready`=1 the first cycle after reset.

## Test plan
- SW 0x11223344 @0x100, then LW @0x100 -> byte_enable 1111, mem bytes 0x100..0x103 = 44,33,22,11; rsp_rdata 0x11223344, rsp_valid 2 cycles after accept (WAIT_CYCLES=0).
- After above: LB @0x103 -> 0x00000011; LH @0x102 -> 0x00001122; SB 0x80 @0x101 (byte_enable 0010, write_data 0x00008000), then LB @0x101 -> 0xFFFFFF80, LBU -> 0x00000080, LW @0x100 -> 0x11228044.
- SH 0xBEEF @0x102 -> byte_enable 1100, write_data 0xBEEF0000; LHU @0x102 -> 0x0000BEEF, LH -> 0xFFFFBEEF.
- LW @0x102, SH @0x101, funct3=011 -> rsp_fault=1, rsp_rdata=0, rsp_valid at T+1, mem_write_en never asserted, memory unchanged.
- WAIT_CYCLES=3, rsp_ready held low 5 cycles: rsp_valid at T+5, write_en single pulse at T+4, rsp held stable, req_ready low until cycle after rsp_ready.
- rst asserted during ACCESS of a store with WAIT_CYCLES=3 -> no write_en pulse, all outputs at reset values, req_ready=1 next cycle.
